// File: rtl/sc_nco_pkg.sv
// Shared definitions for the sine/cosine NCO: quadrant encodings, pipeline
// latency and the quarter-wave table entry formula.
package sc_nco_pkg;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    // Edges from phase capture to the sample appearing on the outputs.
    localparam int LAT = 3;

    localparam real QW_PI   = 3.14159265358979323846;
    // Entries are sampled mid-step so that every table value is nonzero.
    localparam real QW_HALF = 0.5;

    // T[k] = round((2^(dsz-1)-1) * sin((k+0.5)*pi/2^(asz-1)))
    function automatic int qw_entry(input int k, input int asz, input int dsz);
        real amp;
        real step;
        amp  = real'((32'd1 << (dsz - 1)) - 32'd1);
        step = QW_PI / real'(32'd1 << (asz - 1));
        return $rtoi(amp * $sin((real'(k) + QW_HALF) * step) + QW_HALF);
    endfunction

endpackage

// File: rtl/sc_nco_if.sv
// Control and sample bus of the NCO: phase/frequency controls in, sin/cos out.
interface sc_nco_if #(
    parameter int PSZ = 32,
    parameter int DSZ = 14
);
    logic           en;
    logic           fcw_ld;
    logic [PSZ-1:0] fcw;
    logic [PSZ-1:0] phase_ofs;
    logic           sync;
    logic [DSZ-1:0] sin_o;
    logic [DSZ-1:0] cos_o;
    logic           valid_o;

    modport master (
        output en, fcw_ld, fcw, phase_ofs, sync,
        input  sin_o, cos_o, valid_o
    );

    modport slave (
        input  en, fcw_ld, fcw, phase_ofs, sync,
        output sin_o, cos_o, valid_o
    );
endinterface

// File: rtl/sc_qrom.sv
// Dual-read-port quarter-wave sine ROM with registered outputs; contents are
// computed at elaboration time from the table formula in sc_nco_pkg.
module sc_qrom #(
    parameter int ASZ = 10,
    parameter int DSZ = 14
) (
    input  logic           clk,
    input  logic [ASZ-3:0] addr_a,
    input  logic [ASZ-3:0] addr_b,
    output logic [DSZ-2:0] data_a,
    output logic [DSZ-2:0] data_b
);
    import sc_nco_pkg::*;

    localparam int DEPTH = 1 << (ASZ - 2);

    logic [DSZ-2:0] rom_s [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_tab
        localparam int ENTRY = qw_entry(g, ASZ, DSZ);
        assign rom_s[g] = (DSZ-1)'(ENTRY);
    end

    // Synchronous read on both ports; no reset so the array maps to block RAM.
    always_ff @(posedge clk) begin
        data_a <= rom_s[addr_a];
        data_b <= rom_s[addr_b];
    end

endmodule

// File: rtl/sc_nco.sv
// Numerically controlled oscillator: phase accumulator with live offset and
// restart, quarter-wave ROM lookup, sin/cos samples out after three edges.
module sc_nco #(
    parameter int PSZ = 32,
    parameter int ASZ = 10,
    parameter int DSZ = 14
) (
    input  logic    clk,
    input  logic    rst_n,
    sc_nco_if.slave bus
);
    import sc_nco_pkg::*;

    localparam int IW = ASZ - 2;

    logic [PSZ-1:0] acc_r;
    logic [PSZ-1:0] fcw_r;
    logic [PSZ-1:0] phase_r;
    logic [PSZ-1:0] acc_nxt_s;
    logic [PSZ-1:0] phase_nxt_s;
    logic           cap_s;

    logic [ASZ-1:0] addr_s;
    quad_e          sin_q_s;
    quad_e          cos_q_s;
    logic [IW-1:0]  idx_s;
    logic [IW:0]    sin_fold_s;
    logic [IW:0]    cos_fold_s;

    logic [IW-1:0]  sin_idx_r;
    logic [IW-1:0]  cos_idx_r;
    logic           sin_neg1_r;
    logic           cos_neg1_r;
    logic           sin_neg2_r;
    logic           cos_neg2_r;
    logic [LAT-1:0] vld_r;

    logic [DSZ-2:0] sin_mag_s;
    logic [DSZ-2:0] cos_mag_s;

    // Map a quadrant and in-quadrant index to {negate, table index}.
    function automatic logic [IW:0] fold(input quad_e q, input logic [IW-1:0] i);
        logic [IW:0] r;
        case (q)
            QUAD_0:  r = {1'b0, i};
            QUAD_1:  r = {1'b0, ~i};
            QUAD_2:  r = {1'b1, i};
            QUAD_3:  r = {1'b1, ~i};
            default: r = {1'b0, i};
        endcase
        return r;
    endfunction

    function automatic logic [DSZ-1:0] apply_sign(input logic neg, input logic [DSZ-2:0] mag);
        logic [DSZ-1:0] m;
        m = {1'b0, mag};
        if (neg) begin
            return {DSZ{1'b0}} - m;
        end else begin
            return m;
        end
    endfunction

    // Next accumulator value and E0 phase capture; sync takes priority over en.
    always_comb begin
        acc_nxt_s   = acc_r;
        phase_nxt_s = phase_r;
        cap_s       = 1'b0;
        case ({bus.sync, bus.en})
            2'b11: begin
                phase_nxt_s = bus.phase_ofs;
                acc_nxt_s   = fcw_r;
                cap_s       = 1'b1;
            end
            2'b10: begin
                acc_nxt_s = {PSZ{1'b0}};
            end
            2'b01: begin
                phase_nxt_s = acc_r + bus.phase_ofs;
                acc_nxt_s   = acc_r + fcw_r;
                cap_s       = 1'b1;
            end
            default: begin
                acc_nxt_s   = acc_r;
                phase_nxt_s = phase_r;
                cap_s       = 1'b0;
            end
        endcase
    end

    // Frequency word, accumulator and captured phase registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r   <= {PSZ{1'b0}};
            fcw_r   <= {PSZ{1'b0}};
            phase_r <= {PSZ{1'b0}};
        end else begin
            acc_r <= acc_nxt_s;
            if (bus.fcw_ld) begin
                fcw_r <= bus.fcw;
            end else begin
                fcw_r <= fcw_r;
            end
            if (cap_s) begin
                phase_r <= phase_nxt_s;
            end else begin
                phase_r <= phase_r;
            end
        end
    end

    // Cosine is sine a quarter turn ahead, i.e. the next quadrant, same index.
    always_comb begin
        addr_s     = ASZ'(phase_r >> (PSZ - ASZ));
        idx_s      = addr_s[IW-1:0];
        sin_q_s    = quad_e'(addr_s[ASZ-1 -: 2]);
        cos_q_s    = quad_e'(addr_s[ASZ-1 -: 2] + 2'd1);
        sin_fold_s = fold(sin_q_s, idx_s);
        cos_fold_s = fold(cos_q_s, idx_s);
    end

    // E1 address/sign registers, E2 sign delay alongside the ROM read, valid pipe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sin_idx_r  <= {IW{1'b0}};
            cos_idx_r  <= {IW{1'b0}};
            sin_neg1_r <= 1'b0;
            cos_neg1_r <= 1'b0;
            sin_neg2_r <= 1'b0;
            cos_neg2_r <= 1'b0;
            vld_r      <= {LAT{1'b0}};
        end else begin
            sin_idx_r  <= sin_fold_s[IW-1:0];
            cos_idx_r  <= cos_fold_s[IW-1:0];
            sin_neg1_r <= sin_fold_s[IW];
            cos_neg1_r <= cos_fold_s[IW];
            sin_neg2_r <= sin_neg1_r;
            cos_neg2_r <= cos_neg1_r;
            vld_r      <= {vld_r[LAT-2:0], cap_s};
        end
    end

    sc_qrom #(
        .ASZ (ASZ),
        .DSZ (DSZ)
    ) u_qrom (
        .clk    (clk),
        .addr_a (sin_idx_r),
        .addr_b (cos_idx_r),
        .data_a (sin_mag_s),
        .data_b (cos_mag_s)
    );

    // E3 sign application; outputs hold their last sample through bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.sin_o   <= {DSZ{1'b0}};
            bus.cos_o   <= {DSZ{1'b0}};
            bus.valid_o <= 1'b0;
        end else begin
            bus.valid_o <= vld_r[LAT-1];
            if (vld_r[LAT-1]) begin
                bus.sin_o <= apply_sign(sin_neg2_r, sin_mag_s);
                bus.cos_o <= apply_sign(cos_neg2_r, cos_mag_s);
            end else begin
                bus.sin_o <= bus.sin_o;
                bus.cos_o <= bus.cos_o;
            end
        end
    end

endmodule

// File: tb/tb_sc_nco.sv
// Scoreboard bench for sc_nco: directed stimulus pushes hand-computed sin/cos
// and the cycle they are due; a negedge monitor pops and compares.
module tb_sc_nco;

    typedef struct {
        int s;
        int c;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_q;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   qn = 0;
    int   last_s = 0;
    int   last_c = 0;
    exp_t sb[$];

    int sin_tab [4] = '{25, 8191, -25, -8191};
    int cos_tab [4] = '{8191, -25, -8191, 25};

    sc_nco_if #(.PSZ(32), .DSZ(14)) bus ();

    sc_nco #(.PSZ(32), .ASZ(10), .DSZ(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    // Monitor: reset state, scoreboard pops on valid, hold check on bubbles.
    always @(negedge clk) begin
        exp_t e;
        int   gs;
        int   gc;
        gs = int'($signed(bus.sin_o));
        gc = int'($signed(bus.cos_o));
        if (rst_q !== 1'b1) begin
            tests++;
            if (bus.valid_o !== 1'b0 || bus.sin_o !== 14'd0 || bus.cos_o !== 14'd0) begin
                fails++;
                $display("FAIL reset_state: got valid=%b sin=%0d cos=%0d, want 0 0 0", bus.valid_o, gs, gc);
            end
            last_s = 0;
            last_c = 0;
        end else if (bus.valid_o === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: got sin=%0d cos=%0d at cyc %0d, want no sample", gs, gc, cyc);
            end else begin
                e = sb.pop_front();
                if (gs !== e.s || gc !== e.c || cyc !== e.due) begin
                    fails++;
                    $display("FAIL sample: got sin=%0d cos=%0d cyc=%0d, want sin=%0d cos=%0d cyc=%0d",
                             gs, gc, cyc, e.s, e.c, e.due);
                end
                last_s = e.s;
                last_c = e.c;
            end
        end else begin
            tests++;
            if (bus.valid_o !== 1'b0 || gs !== last_s || gc !== last_c) begin
                fails++;
                $display("FAIL hold: got valid=%b sin=%0d cos=%0d, want valid=0 sin=%0d cos=%0d",
                         bus.valid_o, gs, gc, last_s, last_c);
            end
        end
    end

    task automatic drive(input logic e, input logic s, input logic ld,
                         input logic [31:0] f, input logic [31:0] o,
                         input int es, input int ec);
        exp_t x;
        @(posedge clk);
        #1;
        bus.en        = e;
        bus.sync      = s;
        bus.fcw_ld    = ld;
        bus.fcw       = f;
        bus.phase_ofs = o;
        if (e) begin
            x.s   = es;
            x.c   = ec;
            x.due = cyc + 4;
            sb.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 0, 0);
        end
    endtask

    // One sample of the quarter-turn stream (fcw = 0x40000000, ofs = 0).
    task automatic stream();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, sin_tab[qn % 4], cos_tab[qn % 4]);
        qn++;
    endtask

    initial begin
        logic [6:0] gaps;
        int         waited;
        gaps          = 7'b1001101;
        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.sync      = 1'b0;
        bus.fcw_ld    = 1'b0;
        bus.fcw       = 32'd0;
        bus.phase_ofs = 32'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);

        // fcw_reg is 0 after reset: constant phase from the offset alone
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 25, 8191);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 25, 8191);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'h4000_0000, 8191, -25);

        // quarter-turn frequency word, continuous then gapped enables
        drive(1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'd0, 0, 0);
        idle(1);
        qn = 0;
        for (int i = 0; i < 8; i++) stream();
        for (int i = 0; i < 7; i++) begin
            if (gaps[i]) stream();
            else idle(1);
        end
        idle(2);

        // restart with offset, then advance by fcw_reg
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h4000_0000, 8191, -25);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'h4000_0000, -25, -8191);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'h4000_0000, -8191, 25);
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 25, 8191);

        // load + sync + en together: sync reloads acc with the old word
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd0, 25, 8191);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 8191, -25);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 8191, 25);

        // wrap-around with fcw = all ones from acc = 0
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 25, 8191);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, -25, 8191);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, -25, 8191);
        idle(5);

        // reset with three samples in flight: none may emerge
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 0, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        bus.en = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(6);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 25, 8191);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 25, 8191);
        idle(1);

        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d samples outstanding, want 0", sb.size());
        end
        idle(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sc_nco.md
SC_NCO -- requirements
Module: sc_nco

Interface
REQ-001 Parameter PSZ, 32, phase accumulator / frequency word width.
REQ-002 Parameter ASZ, 10, full-circle LUT address bits (quarter table holds 2^(ASZ-2) entries); legal 4..12.
REQ-003 Parameter DSZ, 14, signed output word width; legal 8..18.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 en  in  1  sample strobe; one phase sample per cycle with en=1.
REQ-007 fcw_ld  in  1  load frequency control word.
REQ-008 fcw  in  PSZ  unsigned phase increment, modulo 2^PSZ.
REQ-009 phase_ofs  in  PSZ  phase offset added to accumulator, sampled live each en cycle.
REQ-010 sync  in  1  phase restart.
REQ-011 sin_o  out  DSZ  signed sine sample.
REQ-012 cos_o  out  DSZ  signed cosine sample.
REQ-013 valid_o  out  1  sin_o/cos_o hold a new sample this cycle.

Function
REQ-014 fcw_ld=1 at an edge SHALL load fcw_reg<=fcw; new value is used from the following edge.
REQ-015 At an edge with en=1, sync=0: captured phase P=acc+phase_ofs (mod 2^PSZ), acc<=acc+fcw_reg (mod 2^PSZ, wraps silently).
REQ-016 At an edge with sync=1: en=1 captures P=phase_ofs and sets acc<=fcw_reg; en=0 sets acc<=0, no capture.
REQ-017 en=0, sync=0: acc holds; a bubble (valid=0) enters the pipeline.
REQ-018 Address a=P[PSZ-1:PSZ-ASZ]; quadrant q=a[ASZ-1:ASZ-2]; index i=a[ASZ-3:0].
REQ-019 Quarter table entry T[k]=round((2^(DSZ-1)-1)*sin((k+0.5)*pi/2^(ASZ-1))), k=0..2^(ASZ-2)-1; all entries positive, nonzero.
REQ-020 sine: q=0 T[i]; q=1 T[~i]; q=2 -T[i]; q=3 -T[~i].
REQ-021 cosine SHALL equal sine evaluated at address a+2^(ASZ-2) (mod 2^ASZ).
REQ-022 Negation is exact; outputs never reach -2^(DSZ-1); no saturation logic.
REQ-023 Pipeline: E0 capture P / E1 register address+quadrant / E2 registered table read / E3 sign apply into sin_o, cos_o.
REQ-024 Latency fixed at 3 cycles: sample captured at edge k appears with valid_o=1 after edge k+3; bubbles preserved in order.
REQ-025 When valid_o=0, sin_o/cos_o hold their last values.
REQ-026 fcw_ld, sync, en simultaneous: REQ-014 and REQ-016 apply independently (sync uses old fcw_reg).

Reset
REQ-027 rst_n=0 at an edge SHALL set acc=0, fcw_reg=0, all pipeline valid bits=0, sin_o=0, cos_o=0, valid_o=0.
REQ-028 Reset mid-stream SHALL discard all in-flight samples; no stale valid_o after rst_n returns high.
REQ-029 First sample after reset with en=1 and no fcw_ld uses P=phase_ofs and fcw_reg=0 (constant phase).

Structure
REQ-030 Shared package sc_nco_pkg SHALL hold quadrant encodings, latency constant LAT=3, and the table-entry formula constants.
REQ-031 Sub-module sc_qrom: dual-read-port quarter-wave ROM, 2^(ASZ-2) x (DSZ-1) unsigned, synchronous registered read, inferable as block RAM.
REQ-032 Table contents generated at elaboration from REQ-019; no external init file.

Verification (PSZ=32, ASZ=10, DSZ=14; T[0]=25, T[255]=8191)
REQ-033 rst_n=0 two cycles -> sin_o=0, cos_o=0, valid_o=0; held until first en +3 cycles.
REQ-034 fcw=0x40000000 loaded, ofs=0, en=1 continuous -> sin 25,8191,-25,-8191 repeating; cos 8191,-25,-8191,25.
REQ-035 Single en pulse at edge k -> valid_o=1 only in cycle after edge k+3; gaps in en reproduced exactly in valid_o.
REQ-036 fcw=0xFFFFFFFF, acc=0, en=1 -> second sample a=1023, sin=-25, cos=8191 (wrap-around).
REQ-037 sync=1 with en=1, ofs=0x40000000, mid-stream -> sample sin=8191, cos=-25, next sample advances by fcw_reg.
REQ-038 rst_n=0 one cycle with three samples in flight -> valid_o=0 next cycle, no samples emitted until new en.
